// File: rtl/zap_shift_arbiter.sv
// Two-requester round-robin front end to a shared barrel shifter.
// Each result lands in a one-entry tagged output slot. Sticky saturation flags are kept per requester.
module zap_shift_arbiter #(
    parameter int SHIFT_OPS = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [1:0]                   i_req_valid,
    output logic [1:0]                   o_req_ready,
    input  logic [31:0]                  i_source0,
    input  logic [31:0]                  i_source1,
    input  logic [7:0]                   i_amount0,
    input  logic [7:0]                   i_amount1,
    input  logic                         i_carry0,
    input  logic                         i_carry1,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_type0,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_type1,
    output logic                         o_valid,
    input  logic                         i_out_ready,
    output logic [31:0]                  o_result,
    output logic                         o_carry,
    output logic                         o_id,
    output logic [1:0]                   o_sat_sticky,
    input  logic [1:0]                   i_sat_clr,
    input  logic                         i_flush
);
    localparam int TW = $clog2(SHIFT_OPS);

    localparam logic [TW-1:0] T_LSL     = TW'(0);
    localparam logic [TW-1:0] T_LSR     = TW'(1);
    localparam logic [TW-1:0] T_ASR     = TW'(2);
    localparam logic [TW-1:0] T_ROR     = TW'(3);
    localparam logic [TW-1:0] T_RORI    = TW'(4);
    localparam logic [TW-1:0] T_ROR_1   = TW'(5);
    localparam logic [TW-1:0] T_RRC     = TW'(6);
    localparam logic [TW-1:0] T_LSL_SAT = TW'(7);

    typedef struct packed {
        logic [31:0]   src;
        logic [7:0]    amt;
        logic          cin;
        logic [TW-1:0] typ;
    } shift_req_t;

    shift_req_t [1:0] req;
    shift_req_t       sel;
    logic             rr_last;
    logic             slot_free;
    logic [1:0]       grant;
    logic             gnt_id;
    logic             fire;

    assign req[0] = {i_source0, i_amount0, i_carry0, i_type0};
    assign req[1] = {i_source1, i_amount1, i_carry1, i_type1};

    assign slot_free = !o_valid || i_out_ready;

    // Reset is folded in so no handshake can complete while it is asserted.
    always_comb begin
        grant = 2'b00;
        if (!i_reset && slot_free && !i_flush) begin
            case (i_req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign o_req_ready = grant;
    assign fire        = |grant;
    assign gnt_id      = grant[1];
    assign sel         = req[gnt_id];

    logic [32:0] lsl_v, lsr_v, asr_v;
    logic [63:0] rot2;
    logic [31:0] rot, lsl1;
    logic [4:0]  rot_amt;
    logic [31:0] sh_res;
    logic        sh_carry;
    logic        sat_hit;
    logic [1:0]  sat_set;

    always_comb begin
        rot_amt  = sel.amt[4:0];
        lsl_v    = {sel.cin, sel.src} << sel.amt;
        lsr_v    = {sel.src, sel.cin} >> sel.amt;
        asr_v    = $signed({sel.src, sel.cin}) >>> sel.amt;
        rot2     = {sel.src, sel.src} >> rot_amt;
        rot      = rot2[31:0];
        lsl1     = {sel.src[30:0], 1'b0};
        sat_hit  = 1'b0;
        sh_res   = sel.src;
        sh_carry = sel.cin;
        case (sel.typ)
            T_LSL: {sh_carry, sh_res} = lsl_v;
            T_LSR: {sh_res, sh_carry} = lsr_v;
            T_ASR: {sh_res, sh_carry} = asr_v;
            T_ROR: begin
                sh_res = rot;
                if (sel.amt == 8'd0)       sh_carry = sel.cin;
                else if (rot_amt == 5'd0)  sh_carry = sel.src[31];
                else                       sh_carry = rot[31];
            end
            T_RORI, T_ROR_1: begin
                sh_res   = rot;
                sh_carry = (sel.amt != 8'd0) ? rot[31] : sel.cin;
            end
            T_RRC: {sh_res, sh_carry} = {sel.cin, sel.src};
            T_LSL_SAT: begin
                sh_carry = 1'b0;
                sat_hit  = lsl1[31] != sel.src[31];
                if (sat_hit) sh_res = sel.src[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                else         sh_res = lsl1;
            end
            default: begin
                sh_res   = sel.src;
                sh_carry = sel.cin;
            end
        endcase
    end

    always_comb begin
        sat_set = 2'b00;
        for (int n = 0; n < 2; n++)
            sat_set[n] = fire && sat_hit && (gnt_id == 1'(n));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_carry      <= 1'b0;
            o_id         <= 1'b0;
            o_sat_sticky <= '0;
            rr_last      <= 1'b1;
        end else begin
            if (fire) begin
                o_valid  <= 1'b1;
                o_result <= sh_res;
                o_carry  <= sh_carry;
                o_id     <= gnt_id;
                rr_last  <= gnt_id;
            end else if (slot_free || i_flush) begin
                o_valid  <= 1'b0;
            end
            // A set in the same cycle as a clear takes precedence.
            o_sat_sticky <= (o_sat_sticky & ~i_sat_clr) | sat_set;
        end
    end
endmodule

// File: doc/zap_shift_arbiter.md
# zap_shift_arbiter

Shares one combinational barrel shift unit between two requesters, the execute-stage operand path (requester 0) and the load-data alignment path (requester 1). It uses round-robin arbitration over valid/ready handshakes and registers each result in a one-entry output slot with requester tag. It also keeps per-requester sticky saturation flags for LSL_SAT operations. It sits between the issue logic and the ALU operand mux.

## Interface
Parameters:
- SHIFT_OPS, 8, number of shift operation codes; the shift type field is $clog2(SHIFT_OPS) = 3 bits wide.

Ports:
- i_clk  in  1  the only clock; all state updates on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  2  request valid, one bit per requester.
- o_req_ready  out  2  grant/accept, one bit per requester; at most one bit set.
- i_source0 / i_source1  in  32  value to shift.
- i_amount0 / i_amount1  in  8  shift amount.
- i_carry0 / i_carry1  in  1  carry in.
- i_type0 / i_type1  in  3  shift type: LSL=0, LSR=1, ASR=2, ROR=3, RORI=4, ROR_1=5, RRC=6, LSL_SAT=7.
- o_valid  out  1  output slot holds a result.
- i_out_ready  in  1  consumer accepts the output slot.
- o_result  out  32  shifted value.
- o_carry  out  1  shifter carry out.
- o_id  out  1  requester that owns the result.
- o_sat_sticky  out  2  per-requester sticky saturation flag.
- i_sat_clr  in  2  per-requester clear pulse for the sticky flag.
- i_flush  in  1  discards the slot and blocks grants this cycle.

## Operation
- Slot free this cycle when !o_valid, or when o_valid && i_out_ready.
- Grant rule:
  - No grant when the slot is not free, or when i_flush=1.
  - Otherwise grant among the i_req_valid bits.
  - If both bits are set, the requester opposite to rr_last wins.
  - rr_last updates to the granted id on every grant.
- o_req_ready is combinational from the current state and i_req_valid. A handshake is o_req_ready[n] && i_req_valid[n].
- On a handshake, the granted operands drive the shift unit. On the next edge, o_result, o_carry and o_id load, and o_valid is set.
- Shift semantics, amount is the 8-bit value:
  - LSL: {carry,result} = {cin,src} << amt.
  - LSR: {result,carry} = {src,cin} >> amt.
  - ASR: same as LSR but sign-filling.
  - ROR: rotate by amt[4:0]. Carry is cin if amt==0; src[31] if amt[4:0]==0 and amt!=0; result[31] otherwise.
  - RORI and ROR_1: rotate by amt[4:0]. Carry is result[31] if amt!=0, else cin.
  - RRC: {result,carry} = {cin,src}.
  - LSL_SAT: result = src<<1. Saturation occurs when result[31]!=src[31]. On saturation, result is 0x7FFFFFFF if src[31]=0, else 0x80000000. Carry is 0.
- Sticky flags:
  - o_sat_sticky[id] sets on the edge that loads a saturating LSL_SAT result for that id.
  - i_sat_clr[n] clears flag n.
  - If set and clear hit the same bit in the same cycle, set wins.
- Flush:
  - i_flush=1 clears o_valid on the next edge, with no new load and no grant.
  - rr_last is unchanged.
  - Sticky flags are unaffected.
- Slot drain without a new grant: o_valid clears; o_result, o_carry and o_id hold their last values.

## Timing
- Latency is 1 cycle from handshake to o_valid=1.
- Throughput is 1 result per cycle while i_out_ready stays high. The grant and the drain happen in the same cycle.
- Backpressure: when o_valid && !i_out_ready, o_req_ready=0 and the slot contents are held stable.
- Reset values: o_valid=0, o_req_ready=0, o_result=0, o_carry=0, o_id=0, o_sat_sticky=0, rr_last=1 (requester 0 wins the first tie).
- A reset asserted mid-operation drops the slot immediately; no handshake is honoured in that cycle.
- A requester must hold its valid and operands stable until accepted. A request withdrawn before grant is not an error; it is simply never granted.

## Test plan
- Single request: req0 LSL, src 0x80000001, amt 1, cin 0 -> next cycle o_valid=1, o_result=0x00000002, o_carry=1, o_id=0.
- Tie arbitration after reset: both requesters valid continuously, i_out_ready=1 -> grants alternate 0,1,0,1 every cycle with o_id matching; no bubbles.
- Backpressure: o_valid=1 with i_out_ready=0 for 3 cycles -> o_req_ready=0 and o_result stable for those cycles. Raise i_out_ready -> the same-cycle grant lands in the next cycle.
- Saturation: req1 LSL_SAT src 0x40000000 -> o_result=0x7FFFFFFF and o_sat_sticky=2'b10. Then i_sat_clr=2'b10 in the same cycle as another saturating req1 op -> flag stays 1.
- Edge shifts:
  - ROR src 0x00000001 amt 32 -> result 0x00000001, carry 0.
  - ROR amt 0, cin 1 -> carry 1.
  - ASR src 0x80000000 amt 40 -> result 0xFFFFFFFF, carry 1.
  - RRC cin 1, src 0x3 -> result 0x80000001, carry 1.
- Flush and reset: i_flush with o_valid=1 and req0 pending -> next cycle o_valid=0 and no grant. Asynchronous i_reset mid-stream -> all outputs reach their reset values immediately.
